// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared register-file writeback definitions: default address/data widths and
// the request record carried through the per-requester writeback queues.
// -----------------------------------------------------------------------------
package rf_pkg;

   localparam int unsigned REGISTER_ADDRESS_WIDTH = 5;
   localparam int unsigned DATA_WIDTH             = 32;

   typedef struct packed {
      logic [REGISTER_ADDRESS_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0]             data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small per-requester writeback queue. Occupancy is tracked with one valid bit
// per slot, so every stored entry is visible to the parent for hazard tracking.
//
// Ports:
//   clk, a_reset_n : clock, asynchronous active-low reset (empties the queue)
//   push_i/wdata_i : enqueue an entry (caller guarantees !full_o or pop_i)
//   full_o         : no free slot
//   pop_i          : drop the head entry (caller guarantees !empty_o)
//   empty_o        : no stored entry
//   rd_ptr_o       : slot index of the head entry
//   entries_o      : raw storage, qualified by valid_o
//   valid_o        : per-slot occupancy
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter type         wb_req_t   = rf_pkg::wb_req_t,
   localparam int unsigned PtrW      = $clog2(FIFO_DEPTH)
) (
   input  logic                     clk,
   input  logic                     a_reset_n,
   input  logic                     push_i,
   input  wb_req_t                  wdata_i,
   output logic                     full_o,
   input  logic                     pop_i,
   output logic                     empty_o,
   output logic [PtrW-1:0]          rd_ptr_o,
   output wb_req_t [FIFO_DEPTH-1:0] entries_o,
   output logic [FIFO_DEPTH-1:0]    valid_o
);

   wb_req_t [FIFO_DEPTH-1:0] mem_q;
   logic [FIFO_DEPTH-1:0]    valid_q, valid_d;
   logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;

   // Entries are contiguous from rd to wr, so a single slot bit decides each flag.
   assign full_o    = valid_q[wr_ptr_q];
   assign empty_o   = ~valid_q[rd_ptr_q];
   assign rd_ptr_o  = rd_ptr_q;
   assign entries_o = mem_q;
   assign valid_o   = valid_q;

   always_comb begin
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Pop clears before push sets: on a full queue both hit the same slot.
      if (pop_i) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PtrW'(1);
      end
      if (push_i) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PtrW'(1);
      end
   end

   // Power-of-two depth: pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage needs no reset; it is only observed through valid_q.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Merges two writeback streams (ALU and load unit) onto the single register
// file write port. Each requester feeds its own queue; a round-robin pick of
// the queue heads is registered onto the write port, one write per cycle.
//
// Ports:
//   clk, a_reset_n           : clock, asynchronous active-low reset
//   wb0_valid/ready/address/data : requester 0 (ALU writeback)
//   wb1_valid/ready/address/data : requester 1 (load unit writeback)
//   rf_we, rf_address3, rf_write_data : registered register-file write port
//   pending_mask             : bit i set while a queued or issuing write targets i
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int unsigned REGISTER_ADDRESS_WIDTH = rf_pkg::REGISTER_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH             = rf_pkg::DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH             = 2
) (
   input  logic                                clk,
   input  logic                                a_reset_n,
   input  logic                                wb0_valid,
   output logic                                wb0_ready,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0]   wb0_address,
   input  logic [DATA_WIDTH-1:0]               wb0_data,
   input  logic                                wb1_valid,
   output logic                                wb1_ready,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0]   wb1_address,
   input  logic [DATA_WIDTH-1:0]               wb1_data,
   output logic                                rf_we,
   output logic [REGISTER_ADDRESS_WIDTH-1:0]   rf_address3,
   output logic [DATA_WIDTH-1:0]               rf_write_data,
   output logic [(2**REGISTER_ADDRESS_WIDTH)-1:0] pending_mask
);

   import rf_pkg::*;

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   wb_req_t                  req0, req1, issue;
   wb_req_t [FIFO_DEPTH-1:0] entries0, entries1;
   logic [FIFO_DEPTH-1:0]    valid0, valid1;
   logic [PtrW-1:0]          rd_ptr0, rd_ptr1;
   logic                     full0, full1, empty0, empty1;
   logic                     push0, push1;
   logic                     grant0, grant1;

   logic                              last_grant_q;
   logic                              rf_we_q;
   logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address3_q;
   logic [DATA_WIDTH-1:0]             rf_write_data_q;

   // Ready depends only on queue state, never on valid.
   assign wb0_ready = ~full0;
   assign wb1_ready = ~full1;

   // Writes to register 0 complete the handshake but are dropped here.
   assign push0 = wb0_valid & ~full0 & (wb0_address != '0);
   assign push1 = wb1_valid & ~full1 & (wb1_address != '0);

   assign req0.address = wb0_address;
   assign req0.data    = wb0_data;
   assign req1.address = wb1_address;
   assign req1.data    = wb1_data;

   wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .wb_req_t   (wb_req_t)
   ) u_fifo0 (
      .clk       (clk),
      .a_reset_n (a_reset_n),
      .push_i    (push0),
      .wdata_i   (req0),
      .full_o    (full0),
      .pop_i     (grant0),
      .empty_o   (empty0),
      .rd_ptr_o  (rd_ptr0),
      .entries_o (entries0),
      .valid_o   (valid0)
   );

   wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .wb_req_t   (wb_req_t)
   ) u_fifo1 (
      .clk       (clk),
      .a_reset_n (a_reset_n),
      .push_i    (push1),
      .wdata_i   (req1),
      .full_o    (full1),
      .pop_i     (grant1),
      .empty_o   (empty1),
      .rd_ptr_o  (rd_ptr1),
      .entries_o (entries1),
      .valid_o   (valid1)
   );

   // Round robin: with both heads present, requester 0 wins only if 1 won last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!empty0 && (empty1 || last_grant_q)) begin
         grant0 = 1'b1;
      end else if (!empty1) begin
         grant1 = 1'b1;
      end
   end

   assign issue = grant1 ? entries1[rd_ptr1] : entries0[rd_ptr0];

   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         last_grant_q    <= 1'b1;
         rf_we_q         <= 1'b0;
         rf_address3_q   <= '0;
         rf_write_data_q <= '0;
      end else begin
         rf_we_q <= grant0 | grant1;
         if (grant0 || grant1) begin
            last_grant_q    <= grant1;
            rf_address3_q   <= issue.address;
            rf_write_data_q <= issue.data;
         end
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_address3   = rf_address3_q;
   assign rf_write_data = rf_write_data_q;

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         if (valid0[i]) pending_mask[entries0[i].address] = 1'b1;
         if (valid1[i]) pending_mask[entries1[i].address] = 1'b1;
      end
      if (rf_we_q) pending_mask[rf_address3_q] = 1'b1;
   end

endmodule
